dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Arbitrates the single-port data memory between two requesters: port 0 is the core load/store unit; port 1 is the program loader / debug master.
- Converts byte addresses to word indices and checks alignment and range.
- Sequences the memory's MemWr/MemRead strobes and accounts for the memory's one-cycle registered read.
- Returns read data with a single-cycle response pulse to the winning requester.

Parameters:
- NUM_WORDS, 32, number of valid 32-bit words in data memory; word indices 0..NUM_WORDS-1.
- IDX_W, $clog2(NUM_WORDS), word-index width (derived; do not override).
- FIRST_PORT, 0, port that wins the first tie after reset.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- p0_req  input  1  port 0 request; held with we/addr/wdata stable until p0_gnt.
- p0_we  input  1  1=write, 0=read.
- p0_addr  input  32  byte address.
- p0_wdata  input  32  write data.
- p0_gnt  output  1  one-cycle accept pulse.
- p0_rvalid  output  1  one-cycle completion pulse (reads and writes).
- p0_rdata  output  32  read data, valid with p0_rvalid; 0 for writes/errors.
- p0_err  output  1  valid with p0_rvalid; misaligned or out of range.
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata, p1_err: same as port 0.
- mem_wr  output  1  to memory MemWr.
- mem_rd  output  1  to memory MemRead.
- mem_addr  output  32  word index, zero-extended.
- mem_wdata  output  32  to memory write_data.
- mem_rdata  input  32  memory registered read output; valid the cycle after mem_rd.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst high at a clk edge):
  - FSM goes to IDLE; all outputs 0.
  - Round-robin pointer set so FIRST_PORT wins the next tie.
  - An in-flight transaction is dropped with no rvalid; memory contents are untouched.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req is high, pick a winner.
    - Single requester: it wins.
    - Both: the port not granted last wins (round-robin).
  - Winner's gnt is asserted combinationally this cycle; latch we/addr/wdata and the port id; update the pointer.
  - Error check on the latched request: err = addr[1:0]!=0 OR addr[31:2] >= NUM_WORDS.
  - If err, go to RESP, skipping ISSUE; no memory strobe is ever issued.
  - Otherwise go to ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_addr = addr[IDX_W+1:2]; mem_wdata = latched wdata.
  - Write: mem_wr=1, mem_rd=0, then go to RESP.
  - Read: mem_rd=1, mem_wr=0, then go to WAIT.
- WAIT (reads only, 1 cycle): capture mem_rdata into the response register, then go to RESP.
- RESP (1 cycle):
  - Owner's rvalid=1 with rdata/err; the other port's response outputs stay 0; then go to IDLE.
  - rdata is held until the next response to that port.
- Latency from the gnt cycle T:
  - Read: rvalid at T+3.
  - Write: rvalid at T+2; memory updated at the T+1→T+2 edge.
  - Error: rvalid at T+1.
- Throughput: a new gnt is issued only in IDLE, so back-to-back reads are spaced 4 cycles apart.
- Strobe rules:
  - mem_wr and mem_rd are never high together, and are only high in ISSUE.
  - mem_addr/mem_wdata hold their last values outside ISSUE (0 after reset).
- Requests arriving while busy wait; gnt is never asserted outside IDLE.
- At most one gnt and at most one rvalid per cycle across both ports.
- A req dropped before gnt is legal and produces no transaction.

Test Plan:
- Reset, p0 write addr 0x8 data 0xDEADBEEF, then p0 read 0x8 -> gnt at T; mem_wr at T+1 with mem_addr=2; p0_rvalid at T+2; read rvalid at T+3 with p0_rdata=0xDEADBEEF, p0_err=0.
- p0 and p1 both request reads continuously for 4 transactions -> grants alternate p0,p1,p0,p1 (FIRST_PORT=0); no cycle has two gnt or two rvalid.
- p1 read addr 0x6 (misaligned) and addr 0x80 (index 32 ≥ NUM_WORDS) -> each gives p1_rvalid at T+1 with p1_err=1, p1_rdata=0; mem_wr and mem_rd stay 0.
- p1 request arrives in ISSUE of a p0 read -> p1_gnt is withheld until IDLE (cycle after p0 RESP); p1 then completes normally.
- Assert rst in WAIT of a p0 read -> next cycle all outputs 0, busy=0, no p0_rvalid; following p1 read of 0x4 completes with correct data.
- Write the last valid word (addr 0x7C, data 0x12345678) and read it back -> 0x12345678, err=0; mem_addr=31.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for a single-port data memory with a registered read.
// Handles alignment and range checks, sequences the memory strobes and returns responses.

module dmem_arb_port (
    input  logic        clk,
    input  logic        rst,
    input  logic        rsp,
    input  logic        ld,
    input  logic [31:0] ld_data,
    input  logic        err_q,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        err
);
    // rdata is loaded on entry to RESP and held until this port's next response
    always_ff @(posedge clk) begin
        if (rst)     rdata <= '0;
        else if (ld) rdata <= ld_data;
    end

    assign rvalid = rsp;
    assign err    = rsp & err_q;
endmodule

module dmem_arbiter #(
    parameter int NUM_WORDS  = 32,
    parameter int IDX_W      = $clog2(NUM_WORDS),
    parameter int FIRST_PORT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    output logic        p0_err,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic        p1_err,
    output logic        mem_wr,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [31:0] NW = 32'(NUM_WORDS);

    state_t            state, state_nxt;
    logic [1:0]        req, we_in, gnt, rsp, ld, rvalid, perr;
    logic [1:0][31:0]  addr_in, wdata_in, rdata_out;
    logic              win, last, owner, we_q, err_q, sel_err;
    logic [31:0]       sel_addr, ld_data;

    assign req      = {p1_req, p0_req};
    assign we_in    = {p1_we, p0_we};
    assign addr_in  = {p1_addr, p0_addr};
    assign wdata_in = {p1_wdata, p0_wdata};

    // On a tie the port not granted last wins
    always_comb begin
        win      = (req == 2'b11) ? ~last : req[1];
        sel_addr = addr_in[win];
        sel_err  = (sel_addr[1:0] != 2'b00) || ({2'b00, sel_addr[31:2]} >= NW);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        gnt       = '0;
        rsp       = '0;
        ld        = '0;
        mem_wr    = 1'b0;
        mem_rd    = 1'b0;
        ld_data   = (state == WAIT) ? mem_rdata : '0;
        case (state)
            IDLE: begin
                // A grant during reset would be dropped, so withhold it
                if ((|req) && !rst) begin
                    gnt[win]  = 1'b1;
                    state_nxt = sel_err ? RESP : ISSUE;
                    ld[win]   = sel_err;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    mem_wr    = 1'b1;
                    ld[owner] = 1'b1;
                    state_nxt = RESP;
                end else begin
                    mem_rd    = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                ld[owner] = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                rsp[owner] = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Memory address/data are loaded only for legal requests and hold otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            last      <= (FIRST_PORT == 0) ? 1'b1 : 1'b0;
            owner     <= 1'b0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (|gnt) begin
            owner <= win;
            last  <= win;
            we_q  <= we_in[win];
            err_q <= sel_err;
            if (!sel_err) begin
                mem_addr  <= {{(32-IDX_W){1'b0}}, sel_addr[IDX_W+1:2]};
                mem_wdata <= wdata_in[win];
            end
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_port
        dmem_arb_port u_port (
            .clk     (clk),
            .rst     (rst),
            .rsp     (rsp[i]),
            .ld      (ld[i]),
            .ld_data (ld_data),
            .err_q   (err_q),
            .rvalid  (rvalid[i]),
            .rdata   (rdata_out[i]),
            .err     (perr[i])
        );
    end

    assign p0_gnt    = gnt[0];
    assign p1_gnt    = gnt[1];
    assign p0_rvalid = rvalid[0];
    assign p1_rvalid = rvalid[1];
    assign p0_rdata  = rdata_out[0];
    assign p1_rdata  = rdata_out[1];
    assign p0_err    = perr[0];
    assign p1_err    = perr[1];
    assign busy      = (state != IDLE);
endmodule
